// File: rtl/axis_frame_source_pkg.sv
// Shared definitions for the AXI-Stream raster frame source: tuser bit map,
// pattern selector codes and FSM states.
package axis_frame_source_pkg;

    localparam int unsigned TUSER_SOF  = 0;
    localparam int unsigned TUSER_WIN0 = 1;

    typedef enum logic [1:0] {
        PAT_RASTER = 2'd0,
        PAT_CONST  = 2'd1,
        PAT_FREE   = 2'd2,
        PAT_ZERO   = 2'd3
    } pattern_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_GAP    = 2'd3
    } state_e;

endpackage

// File: rtl/axis_frame_source_win.sv
// Registered in-window flag for one window: evaluated on the coordinates of the
// beat about to be presented, held while that beat is stalled.
module axis_frame_source_win
    import axis_frame_source_pkg::*;
#(
    parameter int unsigned C_IMG_BITS = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  update,
    input  logic                  clear,
    input  logic [C_IMG_BITS-1:0] ridx,
    input  logic [C_IMG_BITS-1:0] cidx,
    input  logic [C_IMG_BITS-1:0] left,
    input  logic [C_IMG_BITS-1:0] top,
    input  logic [C_IMG_BITS-1:0] width,
    input  logic [C_IMG_BITS-1:0] height,
    output logic                  in_win
);

    logic [C_IMG_BITS:0] right_ext;
    logic [C_IMG_BITS:0] bottom_ext;
    logic                hit;

    // One extra bit so left+width / top+height never wrap past the frame edge.
    always_comb begin
        right_ext  = {1'b0, left} + {1'b0, width};
        bottom_ext = {1'b0, top} + {1'b0, height};
        hit = ({1'b0, ridx} >= {1'b0, top})  && ({1'b0, ridx} < bottom_ext) &&
              ({1'b0, cidx} >= {1'b0, left}) && ({1'b0, cidx} < right_ext);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            in_win <= 1'b0;
        end else if (clear) begin
            in_win <= 1'b0;
        end else if (update) begin
            in_win <= hit;
        end
    end

endmodule

// File: rtl/axis_frame_source.sv
// AXI-Stream raster frame generator with per-frame latched geometry, SOF/EOL
// sideband, window flags and full tready backpressure.
module axis_frame_source
    import axis_frame_source_pkg::*;
#(
    parameter int unsigned C_PIXEL_WIDTH = 8,
    parameter int unsigned C_IMG_BITS    = 12,
    parameter int unsigned C_WIN_NUM     = 1,
    parameter int unsigned C_ROW_SHIFT   = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            enable,
    input  logic [1:0]                      pattern,
    input  logic [C_PIXEL_WIDTH-1:0]        const_val,
    input  logic [C_IMG_BITS-1:0]           img_width,
    input  logic [C_IMG_BITS-1:0]           img_height,
    input  logic [C_IMG_BITS-1:0]           gap_cycles,
    input  logic [C_WIN_NUM*C_IMG_BITS-1:0] win_left,
    input  logic [C_WIN_NUM*C_IMG_BITS-1:0] win_top,
    input  logic [C_WIN_NUM*C_IMG_BITS-1:0] win_width,
    input  logic [C_WIN_NUM*C_IMG_BITS-1:0] win_height,
    output logic                            m_axis_tvalid,
    output logic [C_PIXEL_WIDTH-1:0]        m_axis_tdata,
    output logic [C_WIN_NUM:0]              m_axis_tuser,
    output logic                            m_axis_tlast,
    input  logic                            m_axis_tready,
    output logic                            busy,
    output logic                            frame_done
);

    localparam logic [C_IMG_BITS-1:0]    ONE_I = 1;
    localparam logic [C_PIXEL_WIDTH-1:0] ONE_P = 1;

    state_e                          state;
    logic [C_IMG_BITS-1:0]           sh_w, sh_h, sh_gap;
    logic [C_WIN_NUM*C_IMG_BITS-1:0] sh_left, sh_top, sh_wwid, sh_whgt;
    pattern_e                        sh_pat;
    logic [C_PIXEL_WIDTH-1:0]        sh_const;

    logic [C_IMG_BITS-1:0]    ridx, cidx, gap_cnt;
    logic [C_PIXEL_WIDTH-1:0] free_cnt;
    logic                     tvalid_r, sof_r, tlast_r, eof_r;
    logic [C_PIXEL_WIDTH-1:0] tdata_r;
    logic [C_WIN_NUM-1:0]     win_flags;

    logic                     hs, start_ok, do_latch, advance_beat, end_beat;
    logic [C_IMG_BITS-1:0]    nxt_r, nxt_c;
    logic [C_PIXEL_WIDTH-1:0] nxt_free, nxt_data, raster;

    // Fields for the next presented beat are computed here so that LOAD and an
    // accepted mid-frame beat share one registered update path.
    always_comb begin
        hs           = tvalid_r & m_axis_tready;
        start_ok     = enable && (img_width != '0) && (img_height != '0);
        end_beat     = (state == ST_ACTIVE) && hs && eof_r;
        advance_beat = (state == ST_LOAD) || ((state == ST_ACTIVE) && hs && !eof_r);
        do_latch     = start_ok && ((state == ST_IDLE) ||
                                    (end_beat && (sh_gap == '0)) ||
                                    ((state == ST_GAP) && (gap_cnt == '0)));
        nxt_r = '0;
        nxt_c = '0;
        if (state != ST_LOAD) begin
            if (cidx == sh_w - ONE_I) begin
                nxt_r = ridx + ONE_I;
            end else begin
                nxt_r = ridx;
                nxt_c = cidx + ONE_I;
            end
        end
        nxt_free = hs ? free_cnt + ONE_P : free_cnt;
        raster   = (C_PIXEL_WIDTH'(nxt_r) << C_ROW_SHIFT) + C_PIXEL_WIDTH'(nxt_c);
        nxt_data = '0;
        unique case (sh_pat)
            PAT_RASTER: nxt_data = raster;
            PAT_CONST:  nxt_data = sh_const;
            PAT_FREE:   nxt_data = nxt_free;
            default:    nxt_data = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sh_w     <= '0;
            sh_h     <= '0;
            sh_gap   <= '0;
            sh_left  <= '0;
            sh_top   <= '0;
            sh_wwid  <= '0;
            sh_whgt  <= '0;
            sh_pat   <= PAT_RASTER;
            sh_const <= '0;
        end else if (do_latch) begin
            sh_w     <= img_width;
            sh_h     <= img_height;
            sh_gap   <= gap_cycles;
            sh_left  <= win_left;
            sh_top   <= win_top;
            sh_wwid  <= win_width;
            sh_whgt  <= win_height;
            sh_pat   <= pattern_e'(pattern);
            sh_const <= const_val;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            tvalid_r <= 1'b0;
            tdata_r  <= '0;
            sof_r    <= 1'b0;
            tlast_r  <= 1'b0;
            eof_r    <= 1'b0;
            ridx     <= '0;
            cidx     <= '0;
            free_cnt <= '0;
            gap_cnt  <= '0;
        end else begin
            if (hs) begin
                free_cnt <= free_cnt + ONE_P;
            end
            unique case (state)
                ST_IDLE: if (start_ok) state <= ST_LOAD;
                ST_LOAD: begin
                    state    <= ST_ACTIVE;
                    tvalid_r <= 1'b1;
                end
                ST_ACTIVE: begin
                    if (end_beat) begin
                        tvalid_r <= 1'b0;
                        tdata_r  <= '0;
                        sof_r    <= 1'b0;
                        tlast_r  <= 1'b0;
                        eof_r    <= 1'b0;
                        if (sh_gap != '0) begin
                            state   <= ST_GAP;
                            gap_cnt <= sh_gap - ONE_I;
                        end else begin
                            state <= start_ok ? ST_LOAD : ST_IDLE;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == '0) begin
                        state <= start_ok ? ST_LOAD : ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - ONE_I;
                    end
                end
                default: state <= ST_IDLE;
            endcase
            if (advance_beat) begin
                ridx    <= nxt_r;
                cidx    <= nxt_c;
                tdata_r <= nxt_data;
                sof_r   <= (nxt_r == '0) && (nxt_c == '0);
                tlast_r <= (nxt_c == sh_w - ONE_I);
                eof_r   <= (nxt_c == sh_w - ONE_I) && (nxt_r == sh_h - ONE_I);
            end
        end
    end

    for (genvar k = 0; k < C_WIN_NUM; k++) begin : g_win
        axis_frame_source_win #(
            .C_IMG_BITS (C_IMG_BITS)
        ) u_win (
            .clk    (clk),
            .reset  (reset),
            .update (advance_beat),
            .clear  (end_beat),
            .ridx   (nxt_r),
            .cidx   (nxt_c),
            .left   (sh_left[k*C_IMG_BITS +: C_IMG_BITS]),
            .top    (sh_top[k*C_IMG_BITS +: C_IMG_BITS]),
            .width  (sh_wwid[k*C_IMG_BITS +: C_IMG_BITS]),
            .height (sh_whgt[k*C_IMG_BITS +: C_IMG_BITS]),
            .in_win (win_flags[k])
        );
    end

    assign m_axis_tvalid                         = tvalid_r;
    assign m_axis_tdata                          = tdata_r;
    assign m_axis_tlast                          = tlast_r;
    assign m_axis_tuser[TUSER_SOF]               = sof_r;
    assign m_axis_tuser[TUSER_WIN0 +: C_WIN_NUM] = win_flags;
    assign busy                                  = (state != ST_IDLE);
    assign frame_done                            = hs && eof_r;

endmodule

// File: tb/tb_axis_frame_source.sv
// Self-checking bench for axis_frame_source: frame-level reference model with a
// per-cycle compare process plus directed scenario checks.
module tb_axis_frame_source;

    localparam int LIM = 4000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [1:0]  pattern = 2'd0;
    logic [7:0]  const_val = 8'd0;
    logic [11:0] img_width = 12'd0, img_height = 12'd0, gap_cycles = 12'd0;
    logic [11:0] win_left = 12'd0, win_top = 12'd0, win_width = 12'd0, win_height = 12'd0;
    logic        tvalid, tlast, busy, frame_done;
    logic [7:0]  tdata;
    logic [1:0]  tuser;
    logic        tready = 1'b0;
    logic        rand_mode = 1'b0;

    axis_frame_source #(
        .C_PIXEL_WIDTH (8),
        .C_IMG_BITS    (12),
        .C_WIN_NUM     (1),
        .C_ROW_SHIFT   (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .pattern       (pattern),
        .const_val     (const_val),
        .img_width     (img_width),
        .img_height    (img_height),
        .gap_cycles    (gap_cycles),
        .win_left      (win_left),
        .win_top       (win_top),
        .win_width     (win_width),
        .win_height    (win_height),
        .m_axis_tvalid (tvalid),
        .m_axis_tdata  (tdata),
        .m_axis_tuser  (tuser),
        .m_axis_tlast  (tlast),
        .m_axis_tready (tready),
        .busy          (busy),
        .frame_done    (frame_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [7:0] data;
        logic [1:0] user;
        logic       last;
        logic       eof;
        logic       is_free;
    } beat_t;

    beat_t expq[$];

    // Stats gathered by the compare process, cleared by the scenarios.
    int stat_beats, stat_sof, stat_last, stat_win, stat_done;
    int win_first, win_last, first_data, first_sof, last_gap;
    int model_free = 0;

    task automatic clear_stats();
        stat_beats = 0; stat_sof = 0; stat_last = 0; stat_win = 0; stat_done = 0;
        win_first = -1; win_last = -1; first_data = -1; first_sof = -1; last_gap = -1;
    endtask

    // Expected frame built straight from the raster rules and current inputs.
    task automatic push_frame();
        int w, h, l, t, ww, wh;
        w = int'(img_width); h = int'(img_height);
        l = int'(win_left); t = int'(win_top); ww = int'(win_width); wh = int'(win_height);
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                beat_t b;
                b.user[0] = (r == 0 && c == 0);
                b.user[1] = (r >= t && r < t + wh && c >= l && c < l + ww);
                b.last    = (c == w - 1);
                b.eof     = (r == h - 1 && c == w - 1);
                b.is_free = (pattern == 2'd2);
                case (pattern)
                    2'd0:    b.data = 8'(r * 16 + c);
                    2'd1:    b.data = const_val;
                    default: b.data = 8'd0;
                endcase
                expq.push_back(b);
            end
        end
    endtask

    logic       stalled_prev = 1'b0;
    logic [7:0] prev_data;
    logic [1:0] prev_user;
    logic       prev_last;
    logic       measuring = 1'b0;
    int         idle_run = 0;

    always @(negedge clk) begin
        beat_t b;
        logic  hs, exp_done;
        int    expd;
        if (reset) begin
            stalled_prev = 1'b0;
            measuring    = 1'b0;
            model_free   = 0;
        end else begin
            hs = tvalid && tready;
            exp_done = 1'b0;
            if (stalled_prev) begin
                chk("stall_valid", int'(tvalid), 1);
                chk("stall_data", int'(tdata), int'(prev_data));
                chk("stall_user", int'(tuser), int'(prev_user));
                chk("stall_last", int'(tlast), int'(prev_last));
            end
            if (measuring) begin
                if (tvalid) begin
                    last_gap  = idle_run;
                    measuring = 1'b0;
                end else begin
                    idle_run++;
                end
            end
            if (hs) begin
                if (expq.size() == 0) begin
                    chk("unexpected_beat", 1, 0);
                end else begin
                    b = expq.pop_front();
                    expd = b.is_free ? (model_free % 256) : int'(b.data);
                    chk("data", int'(tdata), expd);
                    chk("user", int'(tuser), int'(b.user));
                    chk("last", int'(tlast), int'(b.last));
                    exp_done = b.eof;
                    if (stat_beats == 0) begin
                        first_data = int'(tdata);
                        first_sof  = int'(tuser[0]);
                    end
                    stat_beats++;
                    if (tuser[0]) stat_sof++;
                    if (tlast) stat_last++;
                    if (tuser[1]) begin
                        if (win_first < 0) win_first = int'(tdata);
                        win_last = int'(tdata);
                        stat_win++;
                    end
                end
                model_free++;
            end
            chk("frame_done", int'(frame_done), int'(exp_done));
            if (frame_done) stat_done++;
            if (hs && exp_done) begin
                measuring = 1'b1;
                idle_run  = 0;
            end
            stalled_prev = tvalid && !tready;
            prev_data = tdata;
            prev_user = tuser;
            prev_last = tlast;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_mode) tready = 1'($urandom_range(0, 1));
        end
    end

    task automatic setup(input int w, input int h, input int gap, input int l, input int t,
                         input int ww, input int wh, input int pat, input int cv);
        img_width = 12'(w); img_height = 12'(h); gap_cycles = 12'(gap);
        win_left = 12'(l); win_top = 12'(t); win_width = 12'(ww); win_height = 12'(wh);
        pattern = 2'(pat); const_val = 8'(cv);
    endtask

    task automatic wait_start();
        int n = 0;
        while (!tvalid && n < LIM) begin @(negedge clk); n++; end
        if (!tvalid) chk("start_timeout", 0, 1);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!(tvalid && tready && frame_done) && n < LIM) begin @(negedge clk); n++; end
        if (n >= LIM) chk("done_timeout", 0, 1);
        @(negedge clk);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < LIM) begin @(negedge clk); n++; end
        chk("idle_busy", int'(busy), 0);
    endtask

    task automatic wait_beats(input int k);
        int n = 0;
        while (stat_beats < k && n < LIM) begin @(negedge clk); n++; end
        if (stat_beats < k) chk("beat_timeout", stat_beats, k);
    endtask

    task automatic run_frames(input int nf);
        enable = 1'b1;
        for (int f = 0; f < nf; f++) begin
            wait_start();
            if (f == nf - 1) enable = 1'b0;
            wait_done();
        end
        wait_idle();
    endtask

    initial begin
        clear_stats();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_tvalid", int'(tvalid), 0);
        chk("rst_tdata", int'(tdata), 0);
        chk("rst_tuser", int'(tuser), 0);
        chk("rst_tlast", int'(tlast), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(frame_done), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        tready = 1'b1;

        // T1 basic raster with one window
        setup(10, 8, 0, 3, 2, 3, 4, 0, 0);
        @(negedge clk);
        clear_stats();
        push_frame();
        run_frames(1);
        chk("t1_beats", stat_beats, 80);
        chk("t1_sof", stat_sof, 1);
        chk("t1_first", first_data, 0);
        chk("t1_last", stat_last, 8);
        chk("t1_win", stat_win, 12);
        chk("t1_win_first", win_first, 8'h23);
        chk("t1_win_last", win_last, 8'h55);
        chk("t1_done", stat_done, 1);

        // T2 random backpressure, 20 back-to-back frames
        clear_stats();
        for (int i = 0; i < 20; i++) push_frame();
        rand_mode = 1'b1;
        run_frames(20);
        rand_mode = 1'b0;
        @(posedge clk); #1;
        tready = 1'b1;
        @(negedge clk);
        chk("t2_beats", stat_beats, 1600);
        chk("t2_win", stat_win, 240);
        chk("t2_done", stat_done, 20);
        chk("t2_gap", last_gap, 1);

        // T3 enable dropped mid-frame
        clear_stats();
        push_frame();
        enable = 1'b1;
        wait_beats(37);
        enable = 1'b0;
        wait_done();
        wait_idle();
        repeat (4) @(negedge clk);
        chk("t3_beats", stat_beats, 80);
        chk("t3_done", stat_done, 1);
        chk("t3_tvalid", int'(tvalid), 0);

        // T3 gap of 5 between frames
        setup(10, 8, 5, 3, 2, 3, 4, 0, 0);
        clear_stats();
        push_frame();
        push_frame();
        run_frames(2);
        chk("t3_gap", last_gap, 6);
        chk("t3_gap_beats", stat_beats, 160);

        // T4 width changed mid-frame
        setup(10, 8, 0, 3, 2, 3, 4, 0, 0);
        clear_stats();
        push_frame();
        enable = 1'b1;
        wait_beats(20);
        img_width = 12'd4;
        push_frame();
        wait_done();
        wait_start();
        enable = 1'b0;
        wait_done();
        wait_idle();
        chk("t4_beats", stat_beats, 112);
        chk("t4_last", stat_last, 16);
        chk("t4_done", stat_done, 2);

        // T5 single-pixel frames
        setup(1, 1, 0, 0, 0, 0, 0, 0, 0);
        clear_stats();
        for (int i = 0; i < 3; i++) push_frame();
        run_frames(3);
        chk("t5_beats", stat_beats, 3);
        chk("t5_sof", stat_sof, 3);
        chk("t5_last", stat_last, 3);
        chk("t5_win", stat_win, 0);

        // T5 window clipped at bottom-right corner
        setup(10, 8, 0, 9, 7, 4, 4, 0, 0);
        clear_stats();
        push_frame();
        run_frames(1);
        chk("t5_clip_win", stat_win, 1);
        chk("t5_clip_data", win_first, 8'h79);

        // T5 zero width never starts
        setup(0, 8, 0, 0, 0, 0, 0, 0, 0);
        enable = 1'b1;
        repeat (10) @(negedge clk);
        chk("t5_w0_tvalid", int'(tvalid), 0);
        chk("t5_w0_busy", int'(busy), 0);
        enable = 1'b0;

        // Other patterns
        setup(3, 2, 0, 1, 0, 1, 2, 1, 8'hA5);
        clear_stats();
        push_frame();
        run_frames(1);
        chk("pat1_first", first_data, 8'hA5);
        chk("pat1_win", stat_win, 2);
        setup(4, 2, 0, 0, 0, 0, 0, 2, 0);
        clear_stats();
        push_frame();
        push_frame();
        rand_mode = 1'b1;
        run_frames(2);
        rand_mode = 1'b0;
        @(posedge clk); #1;
        tready = 1'b1;
        @(negedge clk);
        chk("pat2_beats", stat_beats, 16);
        setup(4, 2, 0, 0, 0, 0, 0, 3, 8'hFF);
        clear_stats();
        push_frame();
        run_frames(1);
        chk("pat3_first", first_data, 0);

        // T6 reset during a stalled beat
        setup(10, 8, 0, 3, 2, 3, 4, 0, 0);
        clear_stats();
        push_frame();
        enable = 1'b1;
        wait_beats(45);
        @(posedge clk); #1;
        tready = 1'b0;
        @(negedge clk);
        chk("t6_stalled_valid", int'(tvalid), 1);
        @(posedge clk); #1;
        reset = 1'b1;
        enable = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("t6_rst_tvalid", int'(tvalid), 0);
        chk("t6_rst_busy", int'(busy), 0);
        expq.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        tready = 1'b1;
        @(negedge clk);
        clear_stats();
        push_frame();
        run_frames(1);
        chk("t6_first_sof", first_sof, 1);
        chk("t6_first_data", first_data, 0);
        chk("t6_beats", stat_beats, 80);

        chk("queue_empty", expq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
